// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - rasterizer pixel stream to framebuffer SRAM writer
//
// Filters off-screen and repeated pixels from a no-backpressure rasterizer,
// queues survivors in a small FIFO and writes each one through a
// request/acknowledge SRAM port.
//
// Ports:
//   clk, n_rst                 clock, synchronous active-low reset
//   src_x/src_y/src_r/g/b      per-cycle pixel from the rasterizer
//   src_busy, src_done         primitive busy level and done pulse
//   mem_addr, mem_wdata        framebuffer word address and {r,g,b}
//   mem_we, mem_ack            write request (held) and acceptance
//   frame_done                 one-cycle pulse when the primitive is committed
//   overflow                   sticky pixel-dropped flag
//   fifo_count                 registered FIFO occupancy
module pixel_writer #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int ADDR_BITS    = 19,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [WIDTH_BITS-1:0]           src_x,
    input  logic [HEIGHT_BITS-1:0]          src_y,
    input  logic [CHANNEL_BITS-1:0]         src_r,
    input  logic [CHANNEL_BITS-1:0]         src_g,
    input  logic [CHANNEL_BITS-1:0]         src_b,
    input  logic                            src_busy,
    input  logic                            src_done,
    output logic [ADDR_BITS-1:0]            mem_addr,
    output logic [3*CHANNEL_BITS-1:0]       mem_wdata,
    output logic                            mem_we,
    input  logic                            mem_ack,
    output logic                            frame_done,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS   = PTR_BITS + 1;
    localparam int DATA_BITS  = 3 * CHANNEL_BITS;
    localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;

    // Sentinel coordinates double as the exclusive on-screen limits.
    localparam logic [WIDTH_BITS-1:0]  X_SENT     = WIDTH_BITS'(WIDTH);
    localparam logic [HEIGHT_BITS-1:0] Y_SENT     = HEIGHT_BITS'(HEIGHT);
    localparam logic [CNT_BITS-1:0]    FULL_COUNT = CNT_BITS'(FIFO_DEPTH);
    localparam logic [ADDR_BITS-1:0]   ROW_PITCH  = ADDR_BITS'(WIDTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ENTRY_BITS-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_BITS-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]     count_q, count_d;
    logic [WIDTH_BITS-1:0]   last_x_q, last_x_d;
    logic [HEIGHT_BITS-1:0]  last_y_q, last_y_d;
    logic                    busy_q, busy_d;
    logic                    overflow_q, overflow_d;
    logic                    done_pending_q, done_pending_d;
    logic                    frame_done_q, frame_done_d;
    logic [ADDR_BITS-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0]    mem_wdata_q, mem_wdata_d;
    logic                    mem_we_q, mem_we_d;

    logic                    pix_valid;
    logic                    pix_dup;
    logic                    pix_accept;
    logic                    busy_rise;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic                    pending_now;
    logic [ADDR_BITS-1:0]    pix_addr;

    always_comb begin
        pix_valid  = (src_x < X_SENT) && (src_y < Y_SENT);
        busy_rise  = src_busy && !busy_q;
        // A busy rising edge resets the last-pixel register this very cycle,
        // so a pixel arriving alongside it is never treated as a repeat.
        pix_dup    = !busy_rise && (src_x == last_x_q) && (src_y == last_y_q);
        pix_accept = pix_valid && !pix_dup;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_COUNT);
        pix_addr   = ADDR_BITS'(src_y) * ROW_PITCH + ADDR_BITS'(src_x);

        state_d     = state_q;
        pop         = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_q == S_IDLE) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = S_WRITE;
            end
        end else begin
            if (mem_ack) begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end
        if (pop) begin
            {mem_addr_d, mem_wdata_d} = fifo_mem_q[rd_ptr_q];
        end
        mem_we_d = (state_d == S_WRITE);

        // A pop in the same cycle frees the slot, so a full FIFO still
        // takes the new pixel.
        push = pix_accept && (!fifo_full || pop);
        drop = pix_accept && fifo_full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase

        last_x_d = last_x_q;
        last_y_d = last_y_q;
        if (push) begin
            last_x_d = src_x;
            last_y_d = src_y;
        end else if (busy_rise) begin
            last_x_d = X_SENT;
            last_y_d = Y_SENT;
        end

        busy_d     = src_busy;
        overflow_d = (overflow_q && !busy_rise) || drop;

        // Completion is judged on next-cycle state: once the FIFO and the
        // write FSM will both be empty, the primitive is fully committed.
        // A done pulse landing while one is pending simply merges into it.
        pending_now    = done_pending_q || src_done;
        frame_done_d   = pending_now && (count_d == '0) && (state_d == S_IDLE);
        done_pending_d = pending_now && !frame_done_d;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            last_x_q       <= X_SENT;
            last_y_q       <= Y_SENT;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
            done_pending_q <= 1'b0;
            frame_done_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_we_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            last_x_q       <= last_x_d;
            last_y_q       <= last_y_d;
            busy_q         <= busy_d;
            overflow_q     <= overflow_d;
            done_pending_q <= done_pending_d;
            frame_done_q   <= frame_done_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_we_q       <= mem_we_d;
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (n_rst && push) begin
            fifo_mem_q[wr_ptr_q] <= {pix_addr, src_r, src_g, src_b};
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - directed self-checking bench for pixel_writer
module tb_pixel_writer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [9:0]  src_x;
    logic [8:0]  src_y;
    logic [7:0]  src_r, src_g, src_b;
    logic        src_busy, src_done;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        mem_we, mem_ack;
    logic        frame_done, overflow;
    logic [3:0]  fifo_count;

    int n_pass  = 0;
    int n_total = 0;
    int fd_count = 0;
    logic [18:0] wr_log [$];

    always #5 clk = ~clk;

    pixel_writer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .src_x      (src_x),
        .src_y      (src_y),
        .src_r      (src_r),
        .src_g      (src_g),
        .src_b      (src_b),
        .src_busy   (src_busy),
        .src_done   (src_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .frame_done (frame_done),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always @(negedge clk) begin
        if (mem_we && mem_ack) wr_log.push_back(mem_addr);
        if (frame_done) fd_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < wr_log.size()) return 32'(wr_log[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int x, input int y, input int r, input int g, input int b);
        src_x = 10'(x);
        src_y = 9'(y);
        src_r = 8'(r);
        src_g = 8'(g);
        src_b = 8'(b);
    endtask

    task automatic idle_px();
        set_px(640, 480, 0, 0, 0);
    endtask

    initial begin
        n_rst = 1'b0; src_busy = 1'b0; src_done = 1'b0; mem_ack = 1'b0;
        idle_px();
        tick(); tick();
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_count", 32'(fifo_count), 0);
        n_rst = 1'b1;
        tick();

        // single pixel, two-cycle latency
        mem_ack = 1'b1;
        set_px(3, 2, 8'hFF, 8'h00, 8'h80);
        tick();
        chk("single_count_n1", 32'(fifo_count), 1);
        chk("single_we_n1", 32'(mem_we), 0);
        idle_px();
        tick();
        chk("single_we_n2", 32'(mem_we), 1);
        chk("single_addr", 32'(mem_addr), 1283);
        chk("single_wdata", 32'(mem_wdata), 32'hFF0080);
        tick();
        chk("single_we_n3", 32'(mem_we), 0);

        // sentinel and duplicate suppression
        wr_log.delete();
        idle_px(); tick();
        set_px(5, 5, 1, 2, 3); tick();
        set_px(5, 5, 1, 2, 3); tick();
        set_px(5, 5, 1, 2, 3); tick();
        set_px(6, 5, 1, 2, 3); tick();
        idle_px();
        repeat (5) tick();
        chk("dup_writes", 32'(wr_log.size()), 2);
        chk("dup_addr0", log_at(0), 3205);
        chk("dup_addr1", log_at(1), 3206);

        // backpressure: 10 pixels, ack held low
        mem_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_px(10 + i, 7, i, i, i);
            tick();
        end
        idle_px();
        chk("bp_count", 32'(fifo_count), 8);
        chk("bp_overflow", 32'(overflow), 1);
        chk("bp_we", 32'(mem_we), 1);
        chk("bp_head_addr", 32'(mem_addr), 4490);
        wr_log.delete();
        mem_ack = 1'b1;
        repeat (12) tick();
        chk("bp_writes", 32'(wr_log.size()), 9);
        for (int i = 0; i < 9; i++) chk("bp_order", log_at(i), 32'(4490 + i));
        chk("bp_drained", 32'(fifo_count), 0);

        // new primitive: busy edge clears overflow and the last-pixel memory
        set_px(0, 0, 9, 9, 9); tick();
        idle_px();
        repeat (3) tick();
        chk("np_overflow_sticky", 32'(overflow), 1);
        src_busy = 1'b1;
        tick();
        chk("np_overflow_clr", 32'(overflow), 0);
        set_px(0, 0, 9, 9, 9); tick();
        chk("np_accept_00", 32'(fifo_count), 1);
        idle_px();
        repeat (3) tick();
        set_px(0, 0, 9, 9, 9); tick();
        chk("np_dup_no_edge", 32'(fifo_count), 0);
        idle_px();
        src_busy = 1'b0;

        // screen-edge boundaries
        wr_log.delete();
        set_px(640, 5, 1, 1, 1); tick();
        chk("bnd_x640", 32'(fifo_count), 0);
        set_px(0, 480, 1, 1, 1); tick();
        chk("bnd_y480", 32'(fifo_count), 0);
        set_px(639, 479, 1, 1, 1); tick();
        chk("bnd_corner_acc", 32'(fifo_count), 1);
        idle_px();
        repeat (3) tick();
        chk("bnd_writes", 32'(wr_log.size()), 1);
        chk("bnd_corner_addr", log_at(0), 307199);

        // completion with ack every other cycle; 4th ack lands in cycle 8
        wr_log.delete();
        fd_count = 0;
        for (int c = 0; c < 15; c++) begin
            if (c < 4) set_px(20 + c, 1, c, c, c);
            else idle_px();
            src_done = (c == 4);
            mem_ack  = (c % 2 == 0);
            chk("cmp_frame_done", 32'(frame_done), 32'(c == 9));
            tick();
        end
        src_done = 1'b0;
        chk("cmp_pulses", 32'(fd_count), 1);
        chk("cmp_writes", 32'(wr_log.size()), 4);
        for (int i = 0; i < 4; i++) chk("cmp_order", log_at(i), 32'(660 + i));

        // reset in the middle of a write
        wr_log.delete();
        fd_count = 0;
        mem_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_px(30 + c, 2, 7, 7, 7);
            tick();
        end
        idle_px();
        chk("mr_pre_we", 32'(mem_we), 1);
        chk("mr_pre_count", 32'(fifo_count), 3);
        n_rst = 1'b0;
        src_done = 1'b1;
        tick();
        chk("mr_we", 32'(mem_we), 0);
        chk("mr_count", 32'(fifo_count), 0);
        n_rst = 1'b1;
        src_done = 1'b0;
        mem_ack = 1'b1;
        repeat (10) tick();
        chk("mr_no_frame_done", 32'(fd_count), 0);
        chk("mr_no_writes", 32'(wr_log.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
Consumer end of the rasterizer pixel stream. Accepts per-cycle X/Y/RGB from the primitive engines (filled circle, line, etc.), which have no backpressure. Discards off-screen and repeated pixels, buffers the rest in a small FIFO, and writes each one to framebuffer SRAM through a request/acknowledge port. Signals frame_done once the source's done pulse has arrived and every buffered pixel has been written.

Parameters:
WIDTH, 640, screen width in pixels; also the off-screen X sentinel value
HEIGHT, 480, screen height in pixels
WIDTH_BITS, 10, X coordinate width
HEIGHT_BITS, 9, Y coordinate width
CHANNEL_BITS, 8, bits per colour channel
ADDR_BITS, 19, framebuffer word address width
FIFO_DEPTH, 8, pixel FIFO entries (power of 2, at least 2)

Ports:
clk  in  1  system clock
n_rst  in  1  reset, synchronous, active-low
src_x  in  WIDTH_BITS  pixel X from rasterizer
src_y  in  HEIGHT_BITS  pixel Y from rasterizer
src_r  in  CHANNEL_BITS  red
src_g  in  CHANNEL_BITS  green
src_b  in  CHANNEL_BITS  blue
src_busy  in  1  rasterizer busy level
src_done  in  1  rasterizer done pulse
mem_addr  out  ADDR_BITS  framebuffer word address
mem_wdata  out  3*CHANNEL_BITS  pixel data {r,g,b}
mem_we  out  1  write request, held until acknowledged
mem_ack  in  1  SRAM accepted the write this cycle
frame_done  out  1  one-cycle pulse: primitive fully committed
overflow  out  1  sticky: at least one pixel was dropped because the FIFO was full
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clocking: one clock. Reset is synchronous, active-low (n_rst sampled on rising clk).
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, frame_done=0, overflow=0, fifo_count=0. FIFO empty, FSM in IDLE, done_pending=0. Last-pixel register set to sentinel (WIDTH, HEIGHT).
- Reset mid-write drops the outstanding request. mem_we is 0 in the cycle after n_rst is sampled low.
- Valid pixel: src_x < WIDTH and src_y < HEIGHT, evaluated every cycle. Anything else (including the idle sentinel) is ignored.
- Duplicate suppression: drop a valid pixel whose (x,y) equals the last accepted pixel. A rising edge of src_busy resets the last-pixel register to sentinel and clears overflow.
- Address: mem_addr = src_y*WIDTH + src_x, computed before the push, truncated to ADDR_BITS. Data: {r,g,b}.
- Push: an accepted pixel is written into the FIFO at the end of the same cycle.
- Full FIFO: if the FIFO is full and no pop happens that cycle, the pixel is dropped and overflow is set. If a pop happens in the same cycle, the push succeeds. The last-pixel register only updates on a successful push.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the mem_addr/mem_wdata registers and go to WRITE.
  - WRITE: mem_we=1 with address and data held stable. When mem_ack=1, go to IDLE, or go back-to-back if the FIFO is non-empty (pop and stay in WRITE).
- Throughput: one write per cycle when mem_ack is tied to 1.
- Latency: pixel presented in cycle N gives mem_we=1 with that address in cycle N+2, when the FIFO was empty and the FSM was in IDLE.
- mem_ack while mem_we=0 is ignored.
- Completion: src_done sets done_pending. frame_done pulses for exactly one cycle when done_pending=1, the FIFO is empty, the FSM is IDLE, and no push is occurring that cycle; done_pending clears in the same cycle.
- A src_done arriving while done_pending=1 merges into the pending completion: only one frame_done pulse results.
- fifo_count is registered and reflects push/pop after each edge.

Test Plan:
- Single pixel: src_x=3, src_y=2, rgb=FF/00/80, mem_ack=1 -> mem_we high 2 cycles later for one cycle, mem_addr=1283, mem_wdata=0xFF0080.
- Sentinel and duplicates: stream (640,480), (5,5), (5,5), (5,5), (6,5) -> exactly two writes, at addresses 3205 and 3206.
- Backpressure: mem_ack=0, feed 10 distinct valid pixels -> fifo_count saturates at 8 (the FSM holds one more in its output register), overflow=1; after ack, the first 9 addresses are written in order.
- Completion: 4 pixels, then src_done, with mem_ack asserted every other cycle -> frame_done pulses once, in the cycle after the 4th ack, never earlier.
- New primitive: after overflow, raise src_busy -> overflow=0; pixel (0,0) is accepted even if it was the last pixel of the previous primitive.
- Reset mid-write: n_rst=0 while mem_we=1 and fifo_count=3 -> next cycle mem_we=0, fifo_count=0, and no frame_done follows.
